msl_rx_frame_checker: RTL

Downstream stage of `msl_slave_receiver`: consumes its parallel word and frame strobe each millisecond frame. It validates an 8-bit additive checksum and tracks link lock and loss-of-signal. Good frames are buffered in a small FIFO that presents a valid/ready stream to the application. It also keeps saturating error and drop counters for status registers.

---
 rtl/msl_pkg.sv | 24 ++
 rtl/msl_sync_fifo.sv | 68 ++++++
 rtl/msl_rx_frame_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/msl_pkg.sv
// Shared types and helpers for the MSL receive path: link state encoding and
// the 8-bit additive frame checksum.
package msl_pkg;

    localparam int MSL_CSUM_W        = 8;
    localparam int MSL_MAX_PAYLOAD_W = 248;

    typedef enum logic [1:0] {
        DOWN    = 2'd0,
        ACQUIRE = 2'd1,
        UP      = 2'd2
    } msl_link_e;

    // Mod-256 sum of every payload byte; callers zero-extend narrower payloads.
    function automatic logic [MSL_CSUM_W-1:0] msl_csum8(input logic [MSL_MAX_PAYLOAD_W-1:0] payload);
        logic [MSL_CSUM_W-1:0] sum;
        sum = 8'd0;
        for (int i = 0; i < MSL_MAX_PAYLOAD_W / 8; i++) begin
            sum = sum + payload[i*8 +: 8];
        end
        return sum;
    endfunction

endpackage

// File: rtl/msl_sync_fifo.sv
// First-word-fall-through synchronous FIFO. A write into a full FIFO is taken
// only when a pop frees the head slot in the same cycle.
module msl_sync_fifo #(
    parameter int P_WIDTH = 24,
    parameter int P_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [P_WIDTH-1:0]         i_wdata,
    input  logic                       i_pop,
    output logic [P_WIDTH-1:0]         o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(P_DEPTH):0]   o_level
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int LW = AW + 1;

    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [LW-1:0]      count_r;
    logic [LW-1:0]      count_nx_s;
    logic               do_wr_s;
    logic               do_rd_s;

    assign o_full  = (count_r == LW'(P_DEPTH));
    assign o_empty = (count_r == LW'(0));
    assign o_level = count_r;
    assign o_rdata = mem_r[rd_ptr_r];

    assign do_rd_s = i_pop & ~o_empty;
    assign do_wr_s = i_push & (~o_full | do_rd_s);

    // Occupancy next-state from the write/read pair.
    always_comb begin
        count_nx_s = count_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_nx_s = count_r + LW'(1);
            2'b01:   count_nx_s = count_r - LW'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_wr_s) begin
                mem_r[wr_ptr_r] <= i_wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nx_s;
        end
    end

endmodule

// File: rtl/msl_rx_frame_checker.sv
// Validates MSL frames from the slave receiver, tracks link lock / loss of
// signal, and buffers good payloads received while the link is up.
module msl_rx_frame_checker
    import msl_pkg::*;
#(
    parameter int P_DATA_WIDTH  = 32,
    parameter int P_CLK_FREQ    = 1000,
    parameter int P_TIMEOUT_MS  = 3,
    parameter int P_LOCK_FRAMES = 2,
    parameter int P_MAX_BAD     = 3,
    parameter int P_FIFO_DEPTH  = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [P_DATA_WIDTH-1:0]         i_data,
    input  logic                            i_msl_1ms,
    output logic [P_DATA_WIDTH-9:0]         o_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_link_up,
    output logic [15:0]                     o_crc_err_cnt,
    output logic [15:0]                     o_drop_cnt,
    output logic [$clog2(P_FIFO_DEPTH):0]   o_level
);

    localparam int PW        = P_DATA_WIDTH - MSL_CSUM_W;
    localparam int TO_CYCLES = P_CLK_FREQ * P_TIMEOUT_MS;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    localparam int LOCK_W    = $clog2(P_LOCK_FRAMES + 1);
    localparam int BAD_W     = $clog2(P_MAX_BAD + 1);

    logic                         strobe_q_r;
    logic [P_DATA_WIDTH-1:0]      data_r;
    logic                         eval_r;
    msl_link_e                    state_r, state_nx_s;
    logic [LOCK_W-1:0]            lock_cnt_r, lock_cnt_nx_s;
    logic [BAD_W-1:0]             bad_cnt_r, bad_cnt_nx_s;
    logic                         link_up_r;
    logic [TO_W-1:0]              to_cnt_r;
    logic [15:0]                  crc_err_cnt_r;
    logic [15:0]                  drop_cnt_r;

    logic                         event_s;
    logic                         good_s;
    logic                         eval_good_s;
    logic                         eval_bad_s;
    logic                         timeout_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         drop_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic [MSL_MAX_PAYLOAD_W-1:0] payload_ext_s;

    assign event_s = i_msl_1ms & ~strobe_q_r;

    // Checksum of the registered word, evaluated the cycle after capture.
    always_comb begin
        payload_ext_s         = '0;
        payload_ext_s[PW-1:0] = data_r[PW-1:0];
        good_s = (data_r[P_DATA_WIDTH-1 -: MSL_CSUM_W] == msl_csum8(payload_ext_s));
    end

    assign eval_good_s = eval_r & good_s;
    assign eval_bad_s  = eval_r & ~good_s;
    // A simultaneous frame event wins over the timeout.
    assign timeout_s   = (to_cnt_r == TO_W'(TO_CYCLES - 1)) & ~event_s & (state_r != DOWN);

    // Link FSM next-state and lock / bad-run counters.
    always_comb begin
        state_nx_s    = state_r;
        lock_cnt_nx_s = lock_cnt_r;
        bad_cnt_nx_s  = bad_cnt_r;
        case (state_r)
            DOWN: begin
                if (eval_good_s) begin
                    if (P_LOCK_FRAMES <= 1) begin
                        state_nx_s   = UP;
                        bad_cnt_nx_s = '0;
                    end else begin
                        state_nx_s    = ACQUIRE;
                        lock_cnt_nx_s = LOCK_W'(1);
                    end
                end else begin
                    state_nx_s = DOWN;
                end
            end
            ACQUIRE: begin
                if (eval_good_s) begin
                    if (lock_cnt_r == LOCK_W'(P_LOCK_FRAMES - 1)) begin
                        state_nx_s   = UP;
                        bad_cnt_nx_s = '0;
                    end else begin
                        lock_cnt_nx_s = lock_cnt_r + LOCK_W'(1);
                    end
                end else if (eval_bad_s || timeout_s) begin
                    state_nx_s    = DOWN;
                    lock_cnt_nx_s = '0;
                end else begin
                    state_nx_s = ACQUIRE;
                end
            end
            UP: begin
                if (eval_good_s) begin
                    bad_cnt_nx_s = '0;
                end else if (eval_bad_s) begin
                    if (bad_cnt_r == BAD_W'(P_MAX_BAD - 1)) begin
                        state_nx_s   = DOWN;
                        bad_cnt_nx_s = '0;
                    end else begin
                        bad_cnt_nx_s = bad_cnt_r + BAD_W'(1);
                    end
                end else if (timeout_s) begin
                    state_nx_s   = DOWN;
                    bad_cnt_nx_s = '0;
                end else begin
                    state_nx_s = UP;
                end
            end
            default: begin
                state_nx_s    = DOWN;
                lock_cnt_nx_s = '0;
                bad_cnt_nx_s  = '0;
            end
        endcase
    end

    assign push_s = eval_good_s & (state_r == UP);
    assign pop_s  = o_valid & i_ready;
    assign drop_s = push_s & fifo_full_s & ~pop_s;

    // Edge detect, capture/eval pipeline, FSM state, timeout and status counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            strobe_q_r    <= 1'b1;
            data_r        <= '0;
            eval_r        <= 1'b0;
            state_r       <= DOWN;
            lock_cnt_r    <= '0;
            bad_cnt_r     <= '0;
            link_up_r     <= 1'b0;
            to_cnt_r      <= '0;
            crc_err_cnt_r <= 16'd0;
            drop_cnt_r    <= 16'd0;
        end else begin
            strobe_q_r <= i_msl_1ms;
            eval_r     <= event_s;
            if (event_s) begin
                data_r <= i_data;
            end
            state_r    <= state_nx_s;
            lock_cnt_r <= lock_cnt_nx_s;
            bad_cnt_r  <= bad_cnt_nx_s;
            link_up_r  <= (state_nx_s == UP);
            if (event_s) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_W'(TO_CYCLES - 1)) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if (eval_bad_s && (crc_err_cnt_r != 16'hFFFF)) begin
                crc_err_cnt_r <= crc_err_cnt_r + 16'd1;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    msl_sync_fifo #(
        .P_WIDTH (PW),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_s),
        .i_wdata (data_r[PW-1:0]),
        .i_pop   (pop_s),
        .o_rdata (o_data),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s),
        .o_level (o_level)
    );

    assign o_valid       = ~fifo_empty_s;
    assign o_link_up     = link_up_r;
    assign o_crc_err_cnt = crc_err_cnt_r;
    assign o_drop_cnt    = drop_cnt_r;

endmodule
